// File: rtl/cc_fifo_sc_param_pkg.sv
// Shared constants and elaboration-time helpers for the single-clock block-RAM FIFO.
package cc_fifo_sc_param_pkg;

  localparam int MAX_BITS   = 40960;
  localparam int MAX_DATA_W = 40;
  localparam int MIN_DEPTH  = 2;
  localparam int MAX_DEPTH  = 32768;
  localparam int OFFS_W     = 15;
  localparam int LVL_W      = 17;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width/depth table: deepest power-of-two array that fits the RAM bit budget at this width.
  function automatic int max_depth(input int data_w);
    int d;
    d = MAX_DEPTH;
    for (int i = 0; i < 15; i++) begin
      if (d * data_w > MAX_BITS) d = d / 2;
    end
    return d;
  endfunction

  function automatic bit cfg_legal(input int data_w, input int depth);
    return (data_w >= 1) && (data_w <= MAX_DATA_W) &&
           (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) &&
           ((depth & (depth - 1)) == 0) && (depth <= max_depth(data_w));
  endfunction

endpackage

// File: rtl/cc_fifo_flag_gen.sv
// Fill level and almost offsets to FULL/EMPTY/ALMOST flags; purely combinational.
// Zero latency; no flow control of its own.
module cc_fifo_flag_gen
  import cc_fifo_sc_param_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic [LVL_W-1:0]  level,
  input  logic [OFFS_W-1:0] afo,
  input  logic [OFFS_W-1:0] aeo,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [LVL_W-1:0] afo_l;
  logic [LVL_W-1:0] aeo_l;
  logic [LVL_W-1:0] af_thr;

  always_comb begin
    afo_l        = {2'b00, afo};
    aeo_l        = {2'b00, aeo};
    // An offset at or beyond the depth pins the threshold at zero so the flag is always set.
    af_thr       = (afo_l >= DEPTH_L) ? '0 : (DEPTH_L - afo_l);
    full         = (level == DEPTH_L);
    empty        = (level == '0);
    almost_full  = (level >= af_thr);
    almost_empty = (level < aeo_l);
  end

endmodule

// File: rtl/cc_fifo_sc_param.sv
// Single-clock masked-write FIFO with registered or FWFT read; 1-cycle read latency (FWFT: 0).
// Push is rejected at full and pop at empty, each flagged by a one-cycle error pulse.
module cc_fifo_sc_param
  import cc_fifo_sc_param_pkg::*;
#(
  parameter int          DATA_W              = 20,
  parameter int          DEPTH               = 2048,
  parameter int          FWFT                = 0,
  parameter int          DYN_STAT_SELECT     = 1,
  parameter logic [14:0] ALMOST_FULL_OFFSET  = 15'hf,
  parameter logic [14:0] ALMOST_EMPTY_OFFSET = 15'hf
) (
  input  logic              A_CLK,
  input  logic              F_RST_N,
  input  logic              PUSH,
  input  logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] BM,
  input  logic              POP,
  output logic [DATA_W-1:0] DO,
  output logic              DO_VALID,
  input  logic [14:0]       F_ALMOST_FULL_OFFSET,
  input  logic [14:0]       F_ALMOST_EMPTY_OFFSET,
  output logic              F_FULL,
  output logic              F_EMPTY,
  output logic              F_ALMOST_FULL,
  output logic              F_ALMOST_EMPTY,
  output logic              F_WR_ERROR,
  output logic              F_RD_ERROR,
  output logic [15:0]       F_LEVEL,
  output logic [15:0]       F_WR_PTR,
  output logic [15:0]       F_RD_PTR
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  if (!cfg_legal(DATA_W, DEPTH)) begin : g_bad_cfg
    $fatal(1, "cc_fifo_sc_param: illegal DATA_W=%0d / DEPTH=%0d", DATA_W, DEPTH);
  end

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW:0]        level;
  logic [AW-1:0]      wr_addr;
  logic [AW-1:0]      rd_addr;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               full;
  logic               empty;
  logic               push_ok;
  logic               pop_ok;
  logic               wr_err_q;
  logic               rd_err_q;
  logic [14:0]        afo;
  logic [14:0]        aeo;

  assign level   = wr_ptr - rd_ptr;
  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];
  // Reset level gates acceptance so an edge inside reset never lands a write in the array.
  assign push_ok = PUSH && !full && F_RST_N;
  assign pop_ok  = POP && !empty && F_RST_N;

  always_ff @(posedge A_CLK or negedge F_RST_N) begin
    if (!F_RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      wr_err_q <= PUSH && full;
      rd_err_q <= POP && empty;
    end
  end

  always_ff @(posedge A_CLK) begin
    if (push_ok) mem[wr_addr] <= (mem[wr_addr] & ~BM) | (DI & BM);
  end

  if (FWFT != 0) begin : g_fwft
    assign DO       = mem[rd_addr];
    assign DO_VALID = !empty;
  end else begin : g_reg_rd
    logic [DATA_W-1:0] do_q;
    logic              do_vld_q;

    always_ff @(posedge A_CLK or negedge F_RST_N) begin
      if (!F_RST_N) begin
        do_q     <= '0;
        do_vld_q <= 1'b0;
      end else begin
        do_vld_q <= pop_ok;
        if (pop_ok) do_q <= mem[rd_addr];
      end
    end

    assign DO       = do_q;
    assign DO_VALID = do_vld_q;
  end

  assign afo = (DYN_STAT_SELECT != 0) ? F_ALMOST_FULL_OFFSET  : ALMOST_FULL_OFFSET;
  assign aeo = (DYN_STAT_SELECT != 0) ? F_ALMOST_EMPTY_OFFSET : ALMOST_EMPTY_OFFSET;

  cc_fifo_flag_gen #(
    .DEPTH (DEPTH)
  ) u_flag_gen (
    .level        (LVL_W'(level)),
    .afo          (afo),
    .aeo          (aeo),
    .full         (full),
    .empty        (empty),
    .almost_full  (F_ALMOST_FULL),
    .almost_empty (F_ALMOST_EMPTY)
  );

  assign F_FULL     = full;
  assign F_EMPTY    = empty;
  assign F_WR_ERROR = wr_err_q;
  assign F_RD_ERROR = rd_err_q;
  assign F_LEVEL    = 16'(level);
  assign F_WR_PTR   = 16'(wr_addr);
  assign F_RD_PTR   = 16'(rd_addr);

endmodule

// File: tb/tb_cc_fifo_sc_param.sv
// Directed bench: registered-read and FWFT instances driven by the same stimulus.
module tb_cc_fifo_sc_param;

  logic        A_CLK = 1'b0;
  logic        F_RST_N;
  logic        PUSH;
  logic        POP;
  logic [7:0]  DI;
  logic [7:0]  BM;
  logic [14:0] AFO;
  logic [14:0] AEO;

  logic [7:0]  d0_do, d1_do;
  logic        d0_dov, d1_dov;
  logic        d0_full, d1_full, d0_empty, d1_empty;
  logic        d0_af, d1_af, d0_ae, d1_ae;
  logic        d0_werr, d1_werr, d0_rerr, d1_rerr;
  logic [15:0] d0_lvl, d1_lvl, d0_wp, d1_wp, d0_rp, d1_rp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 A_CLK = ~A_CLK;

  cc_fifo_sc_param #(.DATA_W(8), .DEPTH(16), .FWFT(0), .DYN_STAT_SELECT(1)) u_dut (
    .A_CLK(A_CLK), .F_RST_N(F_RST_N), .PUSH(PUSH), .DI(DI), .BM(BM), .POP(POP),
    .DO(d0_do), .DO_VALID(d0_dov),
    .F_ALMOST_FULL_OFFSET(AFO), .F_ALMOST_EMPTY_OFFSET(AEO),
    .F_FULL(d0_full), .F_EMPTY(d0_empty), .F_ALMOST_FULL(d0_af), .F_ALMOST_EMPTY(d0_ae),
    .F_WR_ERROR(d0_werr), .F_RD_ERROR(d0_rerr), .F_LEVEL(d0_lvl),
    .F_WR_PTR(d0_wp), .F_RD_PTR(d0_rp)
  );

  cc_fifo_sc_param #(.DATA_W(8), .DEPTH(16), .FWFT(1), .DYN_STAT_SELECT(1)) u_fwft (
    .A_CLK(A_CLK), .F_RST_N(F_RST_N), .PUSH(PUSH), .DI(DI), .BM(BM), .POP(POP),
    .DO(d1_do), .DO_VALID(d1_dov),
    .F_ALMOST_FULL_OFFSET(AFO), .F_ALMOST_EMPTY_OFFSET(AEO),
    .F_FULL(d1_full), .F_EMPTY(d1_empty), .F_ALMOST_FULL(d1_af), .F_ALMOST_EMPTY(d1_ae),
    .F_WR_ERROR(d1_werr), .F_RD_ERROR(d1_rerr), .F_LEVEL(d1_lvl),
    .F_WR_PTR(d1_wp), .F_RD_PTR(d1_rp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic do_reset();
    F_RST_N = 1'b0;
    step();
    F_RST_N = 1'b1;
  endtask

  initial begin
    F_RST_N = 1'b0;
    PUSH = 1'b0; POP = 1'b0; DI = 8'h00; BM = 8'hFF;
    AFO = 15'd15; AEO = 15'd15;
    step(); step();

    check("rst_empty", d0_empty, 1);
    check("rst_full",  d0_full,  0);
    check("rst_level", d0_lvl,   0);
    check("rst_do",    d0_do,    0);
    check("rst_dov",   d0_dov,   0);
    check("rst_af",    d0_af,    0);
    check("rst_ae",    d0_ae,    1);
    check("rst_errs",  {d0_werr, d0_rerr}, 0);
    F_RST_N = 1'b1;

    // Fill and overflow
    PUSH = 1'b1;
    for (int i = 0; i < 16; i++) begin
      DI = 8'(i);
      step();
    end
    check("fill_full",  d0_full, 1);
    check("fill_level", d0_lvl,  16);
    check("fill_wptr",  d0_wp,   0);
    check("fill_werr0", d0_werr, 0);
    DI = 8'h10;
    step();
    check("ovf_werr",  d0_werr, 1);
    check("ovf_level", d0_lvl,  16);
    PUSH = 1'b0;
    step();
    check("ovf_werr_clr", d0_werr, 0);

    // Drain and underflow
    POP = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("drain_do",  d0_do,  32'(i));
      check("drain_dov", d0_dov, 1);
    end
    step();
    check("udf_rerr",  d0_rerr,  1);
    check("udf_do",    d0_do,    8'h0F);
    check("udf_dov",   d0_dov,   0);
    check("udf_empty", d0_empty, 1);
    POP = 1'b0;
    step();
    check("udf_rerr_clr", d0_rerr, 0);

    // Interleaved push/pop with write-pointer wrap
    for (int k = 0; k < 40; k++) begin
      PUSH = 1'b1; DI = 8'(8'h40 + k);
      step();
      check("wrap_wptr", d0_wp, 32'((k + 1) % 16));
      PUSH = 1'b0; POP = 1'b1;
      step();
      check("wrap_do",  d0_do,  32'(8'h40 + k));
      check("wrap_dov", d0_dov, 1);
      POP = 1'b0;
    end
    check("wrap_rptr", d0_rp, 8);

    // Bit-masked write onto stale contents kept across reset
    do_reset();
    PUSH = 1'b1; DI = 8'hAA; BM = 8'hFF;
    step();
    PUSH = 1'b0; POP = 1'b1;
    step();
    check("mask_seed", d0_do, 8'hAA);
    POP = 1'b0;
    do_reset();
    PUSH = 1'b1; DI = 8'h55; BM = 8'h0F;
    step();
    PUSH = 1'b0; BM = 8'hFF; POP = 1'b1;
    step();
    check("mask_do", d0_do, 8'hA5);
    POP = 1'b0;

    // Simultaneous push+pop at mid level, full and empty
    PUSH = 1'b1;
    for (int k = 0; k < 5; k++) begin
      DI = 8'(8'h60 + k);
      step();
    end
    POP = 1'b1; DI = 8'h65;
    step();
    check("sim5_level", d0_lvl, 5);
    check("sim5_do",    d0_do,  8'h60);
    POP = 1'b0;
    for (int k = 0; k < 11; k++) begin
      DI = 8'(8'h66 + k);
      step();
    end
    check("simf_full", d0_full, 1);
    POP = 1'b1; DI = 8'h71;
    step();
    check("simf_level", d0_lvl,  15);
    check("simf_werr",  d0_werr, 1);
    check("simf_do",    d0_do,   8'h61);
    PUSH = 1'b0;
    for (int k = 0; k < 15; k++) step();
    check("sim_drain_do",    d0_do,    8'h70);
    check("sim_drain_empty", d0_empty, 1);
    PUSH = 1'b1; DI = 8'h77;
    step();
    check("sime_level", d0_lvl,  1);
    check("sime_rerr",  d0_rerr, 1);
    check("sime_dov",   d0_dov,  0);
    PUSH = 1'b0;
    step();
    check("sime_do", d0_do, 8'h77);
    POP = 1'b0;

    // Almost flags from dynamic offsets
    AFO = 15'd4; AEO = 15'd3;
    do_reset();
    check("ae_lvl0", d0_ae, 1);
    PUSH = 1'b1;
    for (int l = 1; l <= 12; l++) begin
      DI = 8'(l);
      step();
      if (l == 2)  check("ae_lvl2",  d0_ae, 1);
      if (l == 3)  check("ae_lvl3",  d0_ae, 0);
      if (l == 11) check("af_lvl11", d0_af, 0);
      if (l == 12) check("af_lvl12", d0_af, 1);
    end
    PUSH = 1'b0;
    do_reset();
    AFO = 15'd20;
    #1;
    check("af_sat_lvl0", d0_af,  1);
    check("af_sat_level", d0_lvl, 0);
    AFO = 15'd15; AEO = 15'd15;

    // FWFT visibility and asynchronous reset
    do_reset();
    PUSH = 1'b1; DI = 8'h3C;
    step();
    check("fwft_do",      d1_do,  8'h3C);
    check("fwft_dov",     d1_dov, 1);
    check("reg_dov_nopop", d0_dov, 0);
    for (int k = 1; k < 8; k++) begin
      DI = 8'(8'h3C + k);
      step();
    end
    PUSH = 1'b0; POP = 1'b1;
    step();
    POP = 1'b0;
    check("fwft_pop_do", d1_do,  8'h3D);
    check("fwft_level7", d1_lvl, 7);
    F_RST_N = 1'b0;
    #1;
    check("arst_empty", d1_empty, 1);
    check("arst_level", d1_lvl,   0);
    check("arst_dov",   d1_dov,   0);
    step();
    F_RST_N = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
